io_mmio_port: RTL and testbench
===============================

// Module: io_mmio_port
// PURPOSE
//   Memory-mapped I/O endpoint on the CPU's byte-wide memory bus, decoding the region mem_a[17:16]==2'b11.
//   CPU writes to 0x30000 and 0x30004 go into a TX FIFO, which drains to the UART through a valid/ready handshake.
//   The block generates io_buffer_full back to the CPU and serves the cycle-counter read at 0x30004-0x30007.
//   It also raises prog_stop once the stop byte has left the FIFO.
// PARAMETERS
//   DEPTH   16  TX FIFO entries; must be a power of 2, >=4
//   MARGIN  4   free-entry headroom that triggers io_buffer_full (covers writes already in flight)
// PORTS
//   clk_in          in   1   single clock
//   rst_in          in   1   reset, asynchronous, active-low
//   rdy_in          in   1   CPU-side enable; low = bus side frozen
//   io_a            in   18  byte address (mem_a[17:0])
//   io_wdata        in   8   write byte (mem_dout)
//   io_wr           in   1   1 = write, 0 = read (mem_wr)
//   io_din          out  8   read data, valid the cycle after the read
//   io_buffer_full  out  1   TX FIFO at or above the high-water mark
//   tx_data         out  8   byte offered to the UART
//   tx_valid        out  1   tx_data valid
//   tx_ready        in   1   UART accepts tx_data this cycle
//   prog_stop       out  1   sticky: program ended and the stop byte has been drained
//   ovf_cnt         out  8   dropped-push counter, saturating
// BEHAVIOUR
//   Reset (rst_in==0, async): FIFO empty, all pointers 0, cycle counter 0, snapshot 0.
//     Outputs: io_din=0, tx_valid=0, tx_data=0, io_buffer_full=0, prog_stop=0, ovf_cnt=0, stop_pending=0.
//   io_acc   = io_a[17:16]==2'b11 && rdy_in.
//   push_req = io_acc && io_wr && !stop_pending && one of:
//     - io_a[2:0]==0 && io_wdata!=0 -> pushes io_wdata;
//     - io_a[2:0]==4                -> pushes 0x00 and sets stop_pending.
//   Writes of 0x00 to 0x30000 are ignored. Any push attempt while stop_pending=1 is ignored and not counted.
//   pop = tx_valid && tx_ready. pop is independent of rdy_in; the UART side keeps draining while the CPU is paused.
//   A push is accepted iff count<DEPTH or pop is asserted in the same cycle, so a full FIFO with a concurrent pop
//     accepts the push and count is unchanged.
//   A rejected push increments ovf_cnt, saturating at 8'hFF.
//   count is $clog2(DEPTH)+1 bits wide; rd_ptr/wr_ptr are $clog2(DEPTH) bits and wrap naturally.
//   tx_valid = (count!=0); tx_data = mem[rd_ptr], combinational from the storage registers.
//   tx_data must stay stable while tx_valid=1 and tx_ready=0.
//   io_buffer_full = (count >= DEPTH-MARGIN); combinational from the count register, no latency.
//   prog_stop: set on the first clock edge where stop_pending=1 && count==0; sticky until reset.
//   Cycle counter: 32-bit, +1 on every clock with rdy_in=1, wraps 0xFFFFFFFF -> 0.
//   Reads (io_acc && !io_wr), result registered into io_din on the next edge:
//     - 0x30000           -> 0x00 (RX is out of scope);
//     - 0x30004           -> byte0 of the live counter; the full 32-bit value is copied into snapshot in the same edge;
//     - 0x30005..0x30007  -> bytes 1..3 of snapshot, so a 4-byte read is coherent;
//     - other IO offsets  -> 0x00.
//   rdy_in=0: io_din, snapshot, cycle counter and stop_pending hold; the FIFO still pops.
//   Non-IO addresses: no push; io_din holds its value.
// TESTING
//   1. Reset, write 0x41 then 0x42 to 0x30000, tx_ready=1 -> tx_data 0x41 then 0x42 on consecutive cycles; tx_valid drops after.
//   2. tx_ready=0, push 12 bytes (DEPTH=16, MARGIN=4) -> io_buffer_full rises on the 12th accepted push.
//      Continue to 20 pushes -> count=16, ovf_cnt=4; first byte popped is the first byte pushed.
//   3. FIFO full, tx_ready=1 and a push in the same cycle -> push accepted, ovf_cnt unchanged, count stays 16.
//   4. Write 0x00 to 0x30000 -> no push. Write any byte to 0x30004 with 3 bytes queued -> 0x00 is sent last;
//      prog_stop rises the cycle after the FIFO empties; a later write to 0x30000 is ignored.
//   5. Force counter=0x123456FF, read 0x30004..0x30007 back-to-back -> io_din = FF, 56, 34, 12 (snapshot coherent).
//   6. Hold rdy_in=0 for 5 cycles while tx drains -> counter and io_din frozen, tx continues.
//      Assert rst_in=0 mid-stream -> tx_valid=0 and all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/io_mmio_port.sv
// Memory-mapped I/O endpoint: TX FIFO toward the UART, stop-byte tracking,
// and a free-running cycle counter readable as a coherent 4-byte value.
module io_mmio_port #(
    parameter int DEPTH  = 16,
    parameter int MARGIN = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [17:0] io_a,
    input  logic [7:0]  io_wdata,
    input  logic        io_wr,
    output logic [7:0]  io_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        prog_stop,
    output logic [7:0]  ovf_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] HIGH_LVL = (AW+1)'(DEPTH - MARGIN);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic [31:0]   cyc_q;
    logic [31:0]   snap_q;
    logic [7:0]    din_q;
    logic [7:0]    din_d;
    logic [7:0]    ovf_q;
    logic          stop_pend_q;
    logic          prog_stop_q;

    logic          io_acc;
    logic          push_req;
    logic          push_stop;
    logic          push_acc;
    logic          pop;
    logic [7:0]    push_byte;
    logic          unused_addr_bits;

    // Only the low three offset bits are decoded; the rest alias inside the region.
    assign unused_addr_bits = ^io_a[15:3];

    always_comb begin
        io_acc    = (io_a[17:16] == 2'b11) && rdy_in;
        push_req  = 1'b0;
        push_stop = 1'b0;
        push_byte = 8'h00;
        if (io_acc && io_wr && !stop_pend_q) begin
            if (io_a[2:0] == 3'd0 && io_wdata != 8'h00) begin
                push_req  = 1'b1;
                push_byte = io_wdata;
            end else if (io_a[2:0] == 3'd4) begin
                push_req  = 1'b1;
                push_stop = 1'b1;
            end
        end

        // A concurrent pop frees a slot, so a full FIFO can still take the push.
        pop      = (count_q != '0) && tx_ready;
        push_acc = push_req && ((count_q < FULL_LVL) || pop);

        count_d = count_q;
        if (push_acc && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_acc && pop) begin
            count_d = count_q - (AW+1)'(1);
        end

        din_d = din_q;
        if (io_acc && !io_wr) begin
            case (io_a[2:0])
                3'd4:    din_d = cyc_q[7:0];
                3'd5:    din_d = snap_q[15:8];
                3'd6:    din_d = snap_q[23:16];
                3'd7:    din_d = snap_q[31:24];
                default: din_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            cyc_q       <= 32'd0;
            snap_q      <= 32'd0;
            din_q       <= 8'h00;
            ovf_q       <= 8'h00;
            stop_pend_q <= 1'b0;
            prog_stop_q <= 1'b0;
        end else begin
            if (push_acc) begin
                mem_q[wr_ptr_q] <= push_byte;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            if (push_req && !push_acc && ovf_q != 8'hFF) begin
                ovf_q <= ovf_q + 8'd1;
            end
            if (push_stop) begin
                stop_pend_q <= 1'b1;
            end
            if (stop_pend_q && count_q == '0) begin
                prog_stop_q <= 1'b1;
            end
            if (rdy_in) begin
                cyc_q <= cyc_q + 32'd1;
            end
            // Snapshot taken with byte0 so bytes 1..3 read back from the same instant.
            if (io_acc && !io_wr && io_a[2:0] == 3'd4) begin
                snap_q <= cyc_q;
            end
            din_q <= din_d;
        end
    end

    assign io_din         = din_q;
    assign io_buffer_full = (count_q >= HIGH_LVL);
    assign tx_valid       = (count_q != '0);
    assign tx_data        = mem_q[rd_ptr_q];
    assign prog_stop      = prog_stop_q;
    assign ovf_cnt        = ovf_q;

endmodule

// File: tb/tb_io_mmio_port.sv
// Self-checking bench for io_mmio_port: a queue-based reference model checked every
// cycle, plus directed sequences with literal expectations.
module tb_io_mmio_port;
    localparam int DEPTH  = 16;
    localparam int MARGIN = 4;

    logic        clk_in   = 1'b0;
    logic        rst_in   = 1'b0;
    logic        rdy_in   = 1'b0;
    logic        io_wr    = 1'b0;
    logic        tx_ready = 1'b0;
    logic [17:0] io_a     = '0;
    logic [7:0]  io_wdata = '0;
    logic [7:0]  io_din;
    logic [7:0]  tx_data;
    logic [7:0]  ovf_cnt;
    logic        io_buffer_full;
    logic        tx_valid;
    logic        prog_stop;

    int compared   = 0;
    int mismatched = 0;
    bit chkEn      = 1'b0;

    // Reference model state
    logic [7:0]  mQueue[$];
    int          mOvf      = 0;
    logic [31:0] mCyc      = '0;
    logic [31:0] mSnap     = '0;
    logic [7:0]  mDin      = '0;
    bit          mStopPend = 1'b0;
    bit          mProgStop = 1'b0;

    io_mmio_port #(.DEPTH(DEPTH), .MARGIN(MARGIN)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .io_a           (io_a),
        .io_wdata       (io_wdata),
        .io_wr          (io_wr),
        .io_din         (io_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .prog_stop      (prog_stop),
        .ovf_cnt        (ovf_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge; inputs change 1 time unit later, then wait one cycle.
    task automatic applyStimulus(input logic [17:0] a, input logic [7:0] d, input logic wr,
                                 input logic rdy, input logic txr);
        #1;
        io_a     = a;
        io_wdata = d;
        io_wr    = wr;
        rdy_in   = rdy;
        tx_ready = txr;
        @(negedge clk_in);
    endtask

    task automatic modelReset();
        mQueue.delete();
        mOvf      = 0;
        mCyc      = '0;
        mSnap     = '0;
        mDin      = '0;
        mStopPend = 1'b0;
        mProgStop = 1'b0;
    endtask

    // One clock edge of the reference model, evaluated from pre-edge state.
    task automatic modelStep();
        int          sz;
        bit          acc;
        bit          doPop;
        bit          pushReq;
        bit          pushStop;
        logic [7:0]  pushByte;
        logic [2:0]  off;
        sz       = mQueue.size();
        acc      = (io_a[17:16] == 2'b11) && rdy_in;
        off      = io_a[2:0];
        doPop    = (sz != 0) && tx_ready;
        pushReq  = 1'b0;
        pushStop = 1'b0;
        pushByte = 8'h00;
        if (acc && io_wr && !mStopPend) begin
            if (off == 3'd0 && io_wdata != 8'h00) begin
                pushReq  = 1'b1;
                pushByte = io_wdata;
            end else if (off == 3'd4) begin
                pushReq  = 1'b1;
                pushStop = 1'b1;
            end
        end
        if (mStopPend && sz == 0) mProgStop = 1'b1;
        if (doPop) void'(mQueue.pop_front());
        if (pushReq) begin
            if (sz < DEPTH || doPop) mQueue.push_back(pushByte);
            else if (mOvf < 255) mOvf++;
        end
        if (pushStop) mStopPend = 1'b1;
        if (acc && !io_wr) begin
            case (off)
                3'd4: begin
                    mDin  = mCyc[7:0];
                    mSnap = mCyc;
                end
                3'd5:    mDin = mSnap[15:8];
                3'd6:    mDin = mSnap[23:16];
                3'd7:    mDin = mSnap[31:24];
                default: mDin = 8'h00;
            endcase
        end
        if (rdy_in) mCyc = mCyc + 32'd1;
    endtask

    // Model advances on every clock edge and clears on the asynchronous reset.
    always begin
        @(posedge clk_in or negedge rst_in);
        if (!rst_in) modelReset();
        else modelStep();
    end

    // Every falling edge, all outputs are compared with the model.
    always @(negedge clk_in) begin
        if (chkEn) begin
            checkOutput("tx_valid", 32'(tx_valid), 32'(mQueue.size() != 0));
            if (mQueue.size() != 0) checkOutput("tx_data", 32'(tx_data), 32'(mQueue[0]));
            checkOutput("io_buffer_full", 32'(io_buffer_full), 32'(mQueue.size() >= DEPTH - MARGIN));
            checkOutput("ovf_cnt", 32'(ovf_cnt), 32'(mOvf));
            checkOutput("prog_stop", 32'(prog_stop), 32'(mProgStop));
            checkOutput("io_din", 32'(io_din), 32'(mDin));
        end
    end

    initial begin
        repeat (3) @(negedge clk_in);
        chkEn = 1'b1;
        checkOutput("reset_tx_valid", 32'(tx_valid), 32'h0);
        checkOutput("reset_tx_data", 32'(tx_data), 32'h0);
        checkOutput("reset_io_din", 32'(io_din), 32'h0);
        checkOutput("reset_ovf", 32'(ovf_cnt), 32'h0);
        rst_in = 1'b1;

        // Cycle counter starts at 0 and freezes while rdy_in is low
        applyStimulus(18'h30004, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("cnt_read0", 32'(io_din), 32'h00);
        applyStimulus(18'h30004, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("cnt_read1", 32'(io_din), 32'h01);
        applyStimulus(18'h30004, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("cnt_frozen", 32'(io_din), 32'h01);
        applyStimulus(18'h30004, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("cnt_read2", 32'(io_din), 32'h02);

        // Two bytes stream straight through
        applyStimulus(18'h30000, 8'h41, 1'b1, 1'b1, 1'b1);
        checkOutput("t1_data0", 32'(tx_data), 32'h41);
        applyStimulus(18'h30000, 8'h42, 1'b1, 1'b1, 1'b1);
        checkOutput("t1_data1", 32'(tx_data), 32'h42);
        applyStimulus(18'h00000, 8'h00, 1'b0, 1'b1, 1'b1);
        checkOutput("t1_valid_drop", 32'(tx_valid), 32'h0);

        // Fill past capacity with the UART stalled
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(18'h30000, 8'(i), 1'b1, 1'b1, 1'b0);
            if (i == 11) checkOutput("t2_full_at11", 32'(io_buffer_full), 32'h0);
            if (i == 12) checkOutput("t2_full_at12", 32'(io_buffer_full), 32'h1);
        end
        checkOutput("t2_ovf", 32'(ovf_cnt), 32'd4);
        checkOutput("t2_first_out", 32'(tx_data), 32'h01);

        // Push into a full FIFO while it pops
        applyStimulus(18'h30000, 8'h55, 1'b1, 1'b1, 1'b1);
        checkOutput("t3_ovf", 32'(ovf_cnt), 32'd4);
        checkOutput("t3_data", 32'(tx_data), 32'h02);
        checkOutput("t3_full", 32'(io_buffer_full), 32'h1);
        repeat (16) applyStimulus(18'h00000, 8'h00, 1'b0, 1'b1, 1'b1);
        checkOutput("t3_drained", 32'(tx_valid), 32'h0);

        // Randomized traffic; stop-byte writes are reserved for the end
        for (int n = 0; n < 800; n++) begin
            logic [17:0] a;
            logic [7:0]  d;
            logic [2:0]  off;
            logic        wr;
            logic        rdy;
            logic        txr;
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) begin
                off = 3'($urandom_range(0, 7));
                if (wr && off == 3'd4) off = 3'd0;
                a = 18'h30000 | 18'(off);
            end else begin
                a = {2'($urandom_range(0, 2)), 16'($urandom)};
            end
            d   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            rdy = ($urandom_range(0, 4) != 0);
            txr = (((n / 100) % 2) == 1) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
            applyStimulus(a, d, wr, rdy, txr);
        end

        // Drain continues while the CPU side is paused
        repeat (DEPTH + 2) applyStimulus(18'h00000, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(18'h30000, 8'hA1 + 8'(i), 1'b1, 1'b1, 1'b0);
        applyStimulus(18'h30004, 8'h00, 1'b0, 1'b1, 1'b0);
        repeat (5) applyStimulus(18'h30005, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("t6_still_valid", 32'(tx_valid), 32'h1);
        checkOutput("t6_last_byte", 32'(tx_data), 32'hA6);
        applyStimulus(18'h00000, 8'h00, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset between clock edges
        #2;
        rst_in = 1'b0;
        #1;
        checkOutput("async_tx_valid", 32'(tx_valid), 32'h0);
        checkOutput("async_tx_data", 32'(tx_data), 32'h0);
        checkOutput("async_ovf", 32'(ovf_cnt), 32'h0);
        checkOutput("async_full", 32'(io_buffer_full), 32'h0);
        checkOutput("async_io_din", 32'(io_din), 32'h0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;

        // Zero write ignored, then stop byte sent last and prog_stop follows
        applyStimulus(18'h30000, 8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("t4_zero_ignored", 32'(tx_valid), 32'h0);
        applyStimulus(18'h30000, 8'h11, 1'b1, 1'b1, 1'b0);
        applyStimulus(18'h30000, 8'h22, 1'b1, 1'b1, 1'b0);
        applyStimulus(18'h30000, 8'h33, 1'b1, 1'b1, 1'b0);
        applyStimulus(18'h30004, 8'h99, 1'b1, 1'b1, 1'b0);
        applyStimulus(18'h30000, 8'h77, 1'b1, 1'b1, 1'b0);
        checkOutput("t4_head", 32'(tx_data), 32'h11);
        applyStimulus(18'h00000, 8'h00, 1'b0, 1'b1, 1'b1);
        checkOutput("t4_b1", 32'(tx_data), 32'h22);
        applyStimulus(18'h00000, 8'h00, 1'b0, 1'b1, 1'b1);
        checkOutput("t4_b2", 32'(tx_data), 32'h33);
        applyStimulus(18'h00000, 8'h00, 1'b0, 1'b1, 1'b1);
        checkOutput("t4_stop_byte", 32'(tx_data), 32'h00);
        checkOutput("t4_stop_valid", 32'(tx_valid), 32'h1);
        applyStimulus(18'h00000, 8'h00, 1'b0, 1'b1, 1'b1);
        checkOutput("t4_empty", 32'(tx_valid), 32'h0);
        checkOutput("t4_stop_not_yet", 32'(prog_stop), 32'h0);
        applyStimulus(18'h00000, 8'h00, 1'b0, 1'b1, 1'b1);
        checkOutput("t4_prog_stop", 32'(prog_stop), 32'h1);
        applyStimulus(18'h30000, 8'h44, 1'b1, 1'b1, 1'b0);
        checkOutput("t4_late_write", 32'(tx_valid), 32'h0);
        checkOutput("t4_ovf", 32'(ovf_cnt), 32'h0);

        chkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
